// File: rtl/darkbus_arbiter.sv
// darkbus_arbiter: shares one darkbus slave between two requesters (M0, M1).
// Round-robin arbitration with a registered grant, a per-owner burst limit
// applied only while the other master is waiting, and a slave timeout that
// completes the access with an error and ERR_DATA.
//
// A master that sees its valid pulse is assumed to keep en high when it has a
// further access queued. A master that has finished lowers en in the next
// cycle. The arbiter treats that cycle as the owner's release.

module darkbus_arbiter #(
   parameter int unsigned MAX_BURST = 4,
   parameter int unsigned TIMEOUT   = 16,
   parameter logic [31:0] ERR_DATA  = 32'hDEAD_BEEF
) (
   input  logic        XCLK,
   input  logic        XRES,

   input  logic        m0_en,
   input  logic        m0_rw,
   input  logic [3:0]  m0_be,
   input  logic [31:0] m0_addr,
   input  logic [31:0] m0_wdata,
   output logic [31:0] m0_rdata,
   output logic        m0_valid,
   output logic        m0_err,

   input  logic        m1_en,
   input  logic        m1_rw,
   input  logic [3:0]  m1_be,
   input  logic [31:0] m1_addr,
   input  logic [31:0] m1_wdata,
   output logic [31:0] m1_rdata,
   output logic        m1_valid,
   output logic        m1_err,

   output logic        s_en,
   output logic        s_rw,
   output logic [3:0]  s_be,
   output logic [31:0] s_addr,
   output logic [31:0] s_wdata,
   input  logic [31:0] s_rdata,
   input  logic        s_valid,

   output logic [1:0]  grant
);

   localparam int unsigned BW = $clog2(MAX_BURST + 1);
   localparam int unsigned TW = $clog2(TIMEOUT);

   // The state encoding doubles as the one-hot grant.
   typedef enum logic [1:0] {
      IDLE = 2'b00,
      OWN0 = 2'b01,
      OWN1 = 2'b10
   } state_t;

   state_t        state_q;
   logic          rr_q;        // 0: M0 preferred on a tie, 1: M1 preferred
   logic [BW-1:0] burst_q;     // completions in the current ownership, saturating
   logic [TW-1:0] tmo_q;       // owned cycles spent waiting for s_valid

   logic          own_en_s;
   logic          oth_en_s;
   logic          own_rw_s;
   logic [3:0]    own_be_s;
   logic [31:0]   own_addr_s;
   logic [31:0]   own_wdata_s;
   state_t        other_s;
   logic          tmo_hit_s;
   logic          done_s;
   logic          limit_s;
   logic [BW-1:0] burst_inc_s;
   logic [31:0]   resp_data_s;

   // Select the owning master's request and the competing master's request.
   always_comb begin
      own_en_s    = 1'b0;
      oth_en_s    = 1'b0;
      own_rw_s    = 1'b0;
      own_be_s    = 4'b0000;
      own_addr_s  = 32'h0000_0000;
      own_wdata_s = 32'h0000_0000;
      other_s     = IDLE;
      case (state_q)
         OWN0: begin
            own_en_s    = m0_en;
            oth_en_s    = m1_en;
            own_rw_s    = m0_rw;
            own_be_s    = m0_be;
            own_addr_s  = m0_addr;
            own_wdata_s = m0_wdata;
            other_s     = OWN1;
         end
         OWN1: begin
            own_en_s    = m1_en;
            oth_en_s    = m0_en;
            own_rw_s    = m1_rw;
            own_be_s    = m1_be;
            own_addr_s  = m1_addr;
            own_wdata_s = m1_wdata;
            other_s     = OWN0;
         end
         default: begin
            other_s = IDLE;
         end
      endcase
   end

   // The timeout cycle suppresses s_en, so a late s_valid in that cycle is
   // ignored. This also keeps s_en free of any path from s_valid.
   assign tmo_hit_s   = (state_q != IDLE) && (tmo_q == TW'(TIMEOUT - 1));
   assign done_s      = own_en_s && (tmo_hit_s || s_valid);
   assign limit_s     = (32'(burst_q) + 32'd1) >= 32'(MAX_BURST);
   assign burst_inc_s = (32'(burst_q) >= 32'(MAX_BURST)) ? burst_q : burst_q + BW'(1);
   assign resp_data_s = tmo_hit_s ? ERR_DATA : s_rdata;

   // Slave-side mux, gated by the registered grant, and the per-master
   // completion signals.
   always_comb begin
      s_en     = own_en_s && !tmo_hit_s;
      s_rw     = own_rw_s;
      s_be     = own_be_s;
      s_addr   = own_addr_s;
      s_wdata  = own_wdata_s;
      m0_valid = 1'b0;
      m0_err   = 1'b0;
      m0_rdata = 32'h0000_0000;
      m1_valid = 1'b0;
      m1_err   = 1'b0;
      m1_rdata = 32'h0000_0000;
      if (done_s && (state_q == OWN0)) begin
         m0_valid = 1'b1;
         m0_err   = tmo_hit_s;
         m0_rdata = resp_data_s;
      end else if (done_s && (state_q == OWN1)) begin
         m1_valid = 1'b1;
         m1_err   = tmo_hit_s;
         m1_rdata = resp_data_s;
      end else begin
         m0_valid = 1'b0;
         m1_valid = 1'b0;
      end
   end

   assign grant = state_q;

   // Ownership FSM with the round-robin pointer, burst and timeout counters.
   always_ff @(posedge XCLK or negedge XRES) begin
      if (!XRES) begin
         state_q <= IDLE;
         rr_q    <= 1'b0;
         burst_q <= '0;
         tmo_q   <= '0;
      end else begin
         case (state_q)
            IDLE: begin
               burst_q <= '0;
               tmo_q   <= '0;
               if (m0_en && (!m1_en || !rr_q)) begin
                  state_q <= OWN0;
               end else if (m1_en) begin
                  state_q <= OWN1;
               end else begin
                  state_q <= IDLE;
               end
            end
            OWN0, OWN1: begin
               if (!own_en_s) begin
                  // Owner released, possibly before completing its access.
                  burst_q <= '0;
                  tmo_q   <= '0;
                  state_q <= oth_en_s ? other_s : IDLE;
               end else if (done_s) begin
                  tmo_q <= '0;
                  rr_q  <= (state_q == OWN0);
                  if (oth_en_s && limit_s) begin
                     state_q <= other_s;
                     burst_q <= '0;
                  end else begin
                     state_q <= state_q;
                     burst_q <= burst_inc_s;
                  end
               end else begin
                  state_q <= state_q;
                  tmo_q   <= tmo_q + TW'(1);
               end
            end
            default: begin
               state_q <= IDLE;
               burst_q <= '0;
               tmo_q   <= '0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_darkbus_arbiter.sv
// Self-checking bench for darkbus_arbiter: directed scenarios with literal
// expectations followed by randomized traffic, all checked every cycle
// against an owner/queue-level model of the arbitration rules.

module tb_darkbus_arbiter;

   localparam int          MB   = 4;
   localparam int          TO   = 16;
   localparam logic [31:0] ERRD = 32'hDEAD_BEEF;

   logic        XCLK = 1'b0;
   logic        XRES = 1'b0;
   logic        m0_en = 1'b0, m0_rw = 1'b0;
   logic [3:0]  m0_be = 4'h0;
   logic [31:0] m0_addr = 32'h0, m0_wdata = 32'h0;
   logic [31:0] m0_rdata;
   logic        m0_valid, m0_err;
   logic        m1_en = 1'b0, m1_rw = 1'b0;
   logic [3:0]  m1_be = 4'h0;
   logic [31:0] m1_addr = 32'h0, m1_wdata = 32'h0;
   logic [31:0] m1_rdata;
   logic        m1_valid, m1_err;
   logic        s_en, s_rw;
   logic [3:0]  s_be;
   logic [31:0] s_addr, s_wdata;
   logic [31:0] s_rdata = 32'h0;
   logic        s_valid = 1'b0;
   logic [1:0]  grant;

   darkbus_arbiter #(.MAX_BURST(MB), .TIMEOUT(TO), .ERR_DATA(ERRD)) dut (
      .XCLK(XCLK), .XRES(XRES),
      .m0_en(m0_en), .m0_rw(m0_rw), .m0_be(m0_be), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
      .m0_rdata(m0_rdata), .m0_valid(m0_valid), .m0_err(m0_err),
      .m1_en(m1_en), .m1_rw(m1_rw), .m1_be(m1_be), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
      .m1_rdata(m1_rdata), .m1_valid(m1_valid), .m1_err(m1_err),
      .s_en(s_en), .s_rw(s_rw), .s_be(s_be), .s_addr(s_addr), .s_wdata(s_wdata),
      .s_rdata(s_rdata), .s_valid(s_valid), .grant(grant)
   );

   always #5 XCLK = ~XCLK;

   int errors = 0;
   int checks = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   // own: 0 = nobody, 1 = M0, 2 = M1. rr: index of the master preferred on a tie.
   int          own = 0, rr = 0, burst = 0, waitc = 0;
   bit          ev   [2];
   bit          eer  [2];
   logic [31:0] erd  [2];
   bit          q_en [2];
   logic        q_rw [2];
   logic [3:0]  q_be [2];
   logic [31:0] q_ad [2];
   logic [31:0] q_wd [2];
   int          o;
   bit          oen, to, done;

   // Compare every cycle on the falling edge, then advance the model.
   always @(negedge XCLK) begin
      if (!XRES) begin
         own = 0; rr = 0; burst = 0; waitc = 0;
         ev[0] = 1'b0; ev[1] = 1'b0;
      end else begin
         q_en[0] = m0_en;  q_en[1] = m1_en;
         q_rw[0] = m0_rw;  q_rw[1] = m1_rw;
         q_be[0] = m0_be;  q_be[1] = m1_be;
         q_ad[0] = m0_addr; q_ad[1] = m1_addr;
         q_wd[0] = m0_wdata; q_wd[1] = m1_wdata;
         o    = (own == 0) ? 0 : own - 1;
         oen  = (own != 0) && q_en[o];
         to   = (own != 0) && (waitc == TO - 1);
         done = oen && (to || (s_valid === 1'b1));
         for (int m = 0; m < 2; m++) begin
            ev[m] = 1'b0; eer[m] = 1'b0; erd[m] = 32'h0;
         end
         if (done) begin
            ev[o]  = 1'b1;
            eer[o] = to;
            erd[o] = to ? ERRD : s_rdata;
         end
         chk("grant", {30'b0, grant}, (own == 1) ? 32'd1 : (own == 2) ? 32'd2 : 32'd0);
         chk("s_en", {31'b0, s_en}, {31'b0, oen && !to});
         chk("s_rw", {31'b0, s_rw}, (own != 0) ? {31'b0, q_rw[o]} : 32'd0);
         chk("s_be", {28'b0, s_be}, (own != 0) ? {28'b0, q_be[o]} : 32'd0);
         chk("s_addr", s_addr, (own != 0) ? q_ad[o] : 32'd0);
         chk("s_wdata", s_wdata, (own != 0) ? q_wd[o] : 32'd0);
         chk("m0_valid", {31'b0, m0_valid}, {31'b0, ev[0]});
         chk("m0_err", {31'b0, m0_err}, {31'b0, eer[0]});
         chk("m0_rdata", m0_rdata, erd[0]);
         chk("m1_valid", {31'b0, m1_valid}, {31'b0, ev[1]});
         chk("m1_err", {31'b0, m1_err}, {31'b0, eer[1]});
         chk("m1_rdata", m1_rdata, erd[1]);
         // next owner
         if (own == 0) begin
            if (q_en[0] || q_en[1]) begin
               own   = (q_en[0] && q_en[1]) ? rr + 1 : (q_en[0] ? 1 : 2);
               burst = 0; waitc = 0;
            end
         end else if (!oen) begin
            own   = q_en[1-o] ? 2 - o : 0;
            burst = 0; waitc = 0;
         end else if (done) begin
            rr    = 1 - o;
            waitc = 0;
            burst = (burst + 1 > MB) ? MB : burst + 1;
            if (q_en[1-o] && burst >= MB) begin
               own   = 2 - o;
               burst = 0;
            end
         end else begin
            waitc++;
         end
      end
   end

   task automatic tick();
      @(posedge XCLK); #1;
   endtask

   task automatic sample();
      @(negedge XCLK); #1;
   endtask

   bit          r_en [2];
   logic        r_rw [2];
   logic [3:0]  r_be [2];
   logic [31:0] r_ad [2];
   logic [31:0] r_wd [2];
   bit          stall;
   int          n0, owned;
   bit          got, idle_seen, hit, early;

   initial begin
      // reset state
      #2;
      chk("rst_grant", {30'b0, grant}, 32'd0);
      chk("rst_s_en", {31'b0, s_en}, 32'd0);
      chk("rst_m0_valid", {31'b0, m0_valid}, 32'd0);
      chk("rst_m1_rdata", m1_rdata, 32'd0);
      tick(); XRES = 1'b1;

      // lone M0 read, slave answers in the same cycle
      tick(); m0_en = 1'b1; m0_rw = 1'b0; m0_addr = 32'h4; s_valid = 1'b1; s_rdata = 32'h1;
      sample();
      chk("t1_idle_grant", {30'b0, grant}, 32'd0);
      chk("t1_idle_s_en", {31'b0, s_en}, 32'd0);
      tick(); sample();
      chk("t1_grant", {30'b0, grant}, 32'd1);
      chk("t1_valid", {31'b0, m0_valid}, 32'd1);
      chk("t1_rdata", m0_rdata, 32'h1);
      chk("t1_s_addr", s_addr, 32'h4);
      tick(); m0_en = 1'b0; s_valid = 1'b0;
      sample();
      chk("t1_release_valid", {31'b0, m0_valid}, 32'd0);
      chk("t1_release_s_en", {31'b0, s_en}, 32'd0);
      tick(); sample();
      chk("t1_idle_after", {30'b0, grant}, 32'd0);

      // M1 byte write passes through untouched
      tick(); m1_en = 1'b1; m1_rw = 1'b1; m1_be = 4'b0100; m1_addr = 32'h8; m1_wdata = 32'h00AA_0000;
      sample();
      chk("t6_idle_s_be", {28'b0, s_be}, 32'd0);
      tick(); sample();
      chk("t6_grant", {30'b0, grant}, 32'd2);
      chk("t6_s_en", {31'b0, s_en}, 32'd1);
      chk("t6_s_rw", {31'b0, s_rw}, 32'd1);
      chk("t6_s_be", {28'b0, s_be}, 32'h4);
      chk("t6_s_addr", s_addr, 32'h8);
      chk("t6_s_wdata", s_wdata, 32'h00AA_0000);
      chk("t6_wait_valid", {31'b0, m1_valid}, 32'd0);
      tick(); s_valid = 1'b1;
      sample();
      chk("t6_valid", {31'b0, m1_valid}, 32'd1);
      chk("t6_m0_quiet", {31'b0, m0_valid}, 32'd0);
      tick(); m1_en = 1'b0; s_valid = 1'b0;
      tick(); tick();

      // M0 streams writes, M1 joins at access 2, burst limit hands over
      n0 = 0; got = 1'b0; idle_seen = 1'b0;
      tick(); m0_en = 1'b1; m0_rw = 1'b1; m0_be = 4'h0; m0_addr = 32'h100; s_valid = 1'b1;
      for (int k = 0; k < 20 && !got; k++) begin
         sample();
         if (m0_valid) n0++;
         if (grant == 2'b10) got = 1'b1;
         else if (grant == 2'b00 && n0 > 0) idle_seen = 1'b1;
         if (!got) begin
            tick();
            m0_wdata = 32'(k);
            m0_addr  = 32'h100 + 32'(4 * k);
            if (n0 >= 2) m1_en = 1'b1;
         end
      end
      chk("t3_m0_accesses", 32'(n0), 32'd4);
      chk("t3_handover", {31'b0, got}, 32'd1);
      chk("t3_no_idle", {31'b0, idle_seen}, 32'd0);
      tick(); m0_en = 1'b0; m1_en = 1'b0; s_valid = 1'b0;
      tick(); tick();

      // slave never answers: timeout on the 16th owned cycle
      owned = 0; hit = 1'b0; early = 1'b0;
      tick(); m0_en = 1'b1; m0_rw = 1'b0; m0_addr = 32'h20; s_valid = 1'b0;
      for (int k = 0; k < 40 && !hit; k++) begin
         sample();
         if (grant == 2'b01) begin
            owned++;
            if (owned == TO) begin
               hit = 1'b1;
               chk("t4_valid", {31'b0, m0_valid}, 32'd1);
               chk("t4_err", {31'b0, m0_err}, 32'd1);
               chk("t4_rdata", m0_rdata, 32'hDEAD_BEEF);
               chk("t4_s_en", {31'b0, s_en}, 32'd0);
            end else if (m0_valid) begin
               early = 1'b1;
            end
         end
         if (!hit) begin
            tick();
            if (owned >= 2) begin m1_en = 1'b1; m1_rw = 1'b0; m1_addr = 32'h30; end
         end
      end
      chk("t4_reached", {31'b0, hit}, 32'd1);
      chk("t4_no_early", {31'b0, early}, 32'd0);
      tick(); m0_en = 1'b0;
      sample();
      chk("t4_m1_pending", {31'b0, m1_valid}, 32'd0);
      tick(); sample();
      chk("t4_next_grant", {30'b0, grant}, 32'd2);

      // reset while M1 waits on the slave
      repeat (3) tick();
      @(posedge XCLK); #3; XRES = 1'b0; #1;
      chk("t5_grant", {30'b0, grant}, 32'd0);
      chk("t5_s_en", {31'b0, s_en}, 32'd0);
      chk("t5_m1_valid", {31'b0, m1_valid}, 32'd0);
      m0_en = 1'b0; m1_en = 1'b0;
      tick(); tick(); XRES = 1'b1;
      tick(); m0_en = 1'b1; m1_en = 1'b1; m0_rw = 1'b0; m1_rw = 1'b0; s_valid = 1'b1; s_rdata = 32'h55;
      sample();
      chk("t5_latency", {30'b0, grant}, 32'd0);
      tick(); sample();
      chk("t2_m0_first", {30'b0, grant}, 32'd1);
      chk("t2_m0_valid", {31'b0, m0_valid}, 32'd1);
      chk("t2_m1_wait", {31'b0, m1_valid}, 32'd0);
      tick(); m0_en = 1'b0;
      sample();
      tick(); sample();
      chk("t2_m1_next", {30'b0, grant}, 32'd2);
      chk("t2_m1_valid", {31'b0, m1_valid}, 32'd1);
      tick(); m1_en = 1'b0; s_valid = 1'b0;
      tick(); tick();

      // randomized traffic with stalls, timeouts and rare early releases
      for (int m = 0; m < 2; m++) r_en[m] = 1'b0;
      stall = 1'b0;
      for (int c = 0; c < 4000; c++) begin
         tick();
         for (int m = 0; m < 2; m++) begin
            if (!r_en[m] || ev[m]) begin
               if ($urandom_range(0, 99) < 55) begin
                  r_en[m] = 1'b1;
                  r_rw[m] = 1'($urandom_range(0, 1));
                  r_be[m] = 4'($urandom_range(0, 15));
                  r_ad[m] = $urandom;
                  r_wd[m] = $urandom;
               end else begin
                  r_en[m] = 1'b0;
               end
            end else if ($urandom_range(0, 199) == 0) begin
               r_en[m] = 1'b0;
            end
         end
         if ($urandom_range(0, 99) < 3) stall = !stall;
         s_valid  = stall ? 1'b0 : 1'($urandom_range(0, 1));
         s_rdata  = $urandom;
         m0_en = r_en[0]; m0_rw = r_rw[0]; m0_be = r_be[0]; m0_addr = r_ad[0]; m0_wdata = r_wd[0];
         m1_en = r_en[1]; m1_rw = r_rw[1]; m1_be = r_be[1]; m1_addr = r_ad[1]; m1_wdata = r_wd[1];
      end
      tick();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
